// File: rtl/mem_stage_dm.sv
// rtl/mem_stage_dm.sv - pipelined MEM stage with req/ack data-memory port and MEM/WB register
module mem_stage_dm #(
    parameter int REG_ADDR_W = 5,
    parameter int ADDR_W     = 32,
    parameter int BIG_ENDIAN = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [REG_ADDR_W-1:0] ex_waddr,
    input  logic                  ex_wreg,
    input  logic [31:0]           ex_wdata,
    input  logic [3:0]            ex_mem_op,
    input  logic [ADDR_W-1:0]     ex_mem_addr,
    input  logic [31:0]           ex_mem_sdata,
    output logic                  dm_req,
    output logic                  dm_we,
    output logic [3:0]            dm_be,
    output logic [ADDR_W-1:0]     dm_addr,
    output logic [31:0]           dm_wdata,
    input  logic                  dm_ack,
    input  logic [31:0]           dm_rdata,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [REG_ADDR_W-1:0] wb_waddr,
    output logic                  wb_wen,
    output logic [31:0]           wb_wdata,
    output logic                  wb_exc
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_t;

    state_t state;

    logic       acc_load;
    logic       acc_store;
    logic       acc_mem;
    size_t      acc_sz;
    logic       misaligned;
    logic       xfer;
    logic [1:0] byte_lane;
    logic       half_hi;
    logic [3:0] req_be;
    logic [31:0] req_wdata;

    logic [3:0]            op_q;
    logic [1:0]            lane_q;
    logic                  half_hi_q;
    logic [REG_ADDR_W-1:0] waddr_q;
    logic                  wreg_q;
    logic [31:0]           alu_q;

    logic        is_load_q;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        acc_load  = 1'b0;
        acc_store = 1'b0;
        acc_sz    = SZ_BYTE;
        case (ex_mem_op)
            OP_LB, OP_LBU: begin acc_load  = 1'b1; acc_sz = SZ_BYTE; end
            OP_LH, OP_LHU: begin acc_load  = 1'b1; acc_sz = SZ_HALF; end
            OP_LW:         begin acc_load  = 1'b1; acc_sz = SZ_WORD; end
            OP_SB:         begin acc_store = 1'b1; acc_sz = SZ_BYTE; end
            OP_SH:         begin acc_store = 1'b1; acc_sz = SZ_HALF; end
            OP_SW:         begin acc_store = 1'b1; acc_sz = SZ_WORD; end
            default:       ;
        endcase
    end

    assign acc_mem    = acc_load | acc_store;
    assign misaligned = acc_mem &&
                        (((acc_sz == SZ_HALF) && ex_mem_addr[0]) ||
                         ((acc_sz == SZ_WORD) && (ex_mem_addr[1:0] != 2'b00)));

    assign ex_ready = reset && (state == S_IDLE) && (!wb_valid || wb_ready);
    assign xfer     = ex_valid && ex_ready;

    // Big-endian mirrors the byte lane, so the halfword half flips as well.
    assign byte_lane = (BIG_ENDIAN != 0) ? (2'd3 - ex_mem_addr[1:0]) : ex_mem_addr[1:0];
    assign half_hi   = ex_mem_addr[1] ^ (BIG_ENDIAN != 0);

    always_comb begin
        req_be    = 4'hf;
        req_wdata = 32'h0;
        if (acc_store) begin
            case (acc_sz)
                SZ_BYTE: begin
                    req_be    = 4'b0001 << byte_lane;
                    req_wdata = {4{ex_mem_sdata[7:0]}};
                end
                SZ_HALF: begin
                    req_be    = half_hi ? 4'b1100 : 4'b0011;
                    req_wdata = {2{ex_mem_sdata[15:0]}};
                end
                default: begin
                    req_be    = 4'hf;
                    req_wdata = ex_mem_sdata;
                end
            endcase
        end
    end

    assign is_load_q = (op_q >= OP_LB) && (op_q <= OP_LW);

    always_comb begin
        case (lane_q)
            2'd0:    ld_byte = dm_rdata[7:0];
            2'd1:    ld_byte = dm_rdata[15:8];
            2'd2:    ld_byte = dm_rdata[23:16];
            default: ld_byte = dm_rdata[31:24];
        endcase
        ld_half = half_hi_q ? dm_rdata[31:16] : dm_rdata[15:0];
        case (op_q)
            OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_data = {24'h0, ld_byte};
            OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_data = {16'h0, ld_half};
            default: ld_data = dm_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            dm_req    <= 1'b0;
            dm_we     <= 1'b0;
            dm_be     <= 4'h0;
            dm_addr   <= '0;
            dm_wdata  <= 32'h0;
            wb_valid  <= 1'b0;
            wb_waddr  <= '0;
            wb_wen    <= 1'b0;
            wb_wdata  <= 32'h0;
            wb_exc    <= 1'b0;
            op_q      <= 4'h0;
            lane_q    <= 2'b00;
            half_hi_q <= 1'b0;
            waddr_q   <= '0;
            wreg_q    <= 1'b0;
            alu_q     <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (xfer) begin
                        if (acc_mem && !misaligned) begin
                            state     <= S_BUSY;
                            dm_req    <= 1'b1;
                            dm_we     <= acc_store;
                            dm_be     <= req_be;
                            dm_addr   <= {ex_mem_addr[ADDR_W-1:2], 2'b00};
                            dm_wdata  <= req_wdata;
                            op_q      <= ex_mem_op;
                            lane_q    <= byte_lane;
                            half_hi_q <= half_hi;
                            waddr_q   <= ex_waddr;
                            wreg_q    <= ex_wreg;
                            alu_q     <= ex_wdata;
                            wb_valid  <= 1'b0;
                        end else begin
                            // NONE and misaligned ops both complete without touching the bus.
                            wb_valid <= 1'b1;
                            wb_waddr <= ex_waddr;
                            wb_wen   <= ex_wreg && !misaligned;
                            wb_wdata <= ex_wdata;
                            wb_exc   <= misaligned;
                        end
                    end else if (wb_ready) begin
                        wb_valid <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (dm_ack) begin
                        state    <= S_IDLE;
                        dm_req   <= 1'b0;
                        dm_we    <= 1'b0;
                        dm_be    <= 4'h0;
                        dm_addr  <= '0;
                        dm_wdata <= 32'h0;
                        wb_valid <= 1'b1;
                        wb_waddr <= waddr_q;
                        wb_wen   <= is_load_q && wreg_q;
                        wb_wdata <= is_load_q ? ld_data : alu_q;
                        wb_exc   <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
